// File: rtl/cci_mpf_shim_buffered_pkg.sv
// Shared types and sizing helpers for the buffered CCI-MPF shim.
package cci_mpf_shim_buffered_pkg;

  localparam int C0_DEPTH_DFLT = 16;
  localparam int C1_DEPTH_DFLT = 16;

  // Occupancy counters must represent 0..DEPTH inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [occ_w(C0_DEPTH_DFLT)-1:0] t_occ_c0;
  typedef logic [occ_w(C1_DEPTH_DFLT)-1:0] t_occ_c1;

  typedef struct packed {
    logic        valid;
    logic [15:0] hdr;
  } t_if_cci_mpf_c0_Tx;

  typedef struct packed {
    logic        valid;
    logic [15:0] hdr;
    logic [63:0] data;
  } t_if_cci_mpf_c1_Tx;

  typedef struct packed {
    logic        mmioRdValid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_if_cci_mpf_c2_Tx;

  typedef struct packed {
    logic        rspValid;
    logic        mmioRdValid;
    logic        mmioWrValid;
    logic [15:0] hdr;
    logic [63:0] data;
  } t_if_cci_mpf_c0_Rx;

  typedef struct packed {
    logic        rspValid;
    logic [15:0] hdr;
  } t_if_cci_mpf_c1_Rx;

endpackage

// File: rtl/cci_mpf_if.sv
// CCI-MPF channel bundle; to_fiu faces the host side, to_afu faces the accelerator.
interface cci_mpf_if;
  import cci_mpf_shim_buffered_pkg::*;

  logic              reset;
  t_if_cci_mpf_c0_Tx c0Tx;
  t_if_cci_mpf_c1_Tx c1Tx;
  t_if_cci_mpf_c2_Tx c2Tx;
  logic              c0TxAlmFull;
  logic              c1TxAlmFull;
  t_if_cci_mpf_c0_Rx c0Rx;
  t_if_cci_mpf_c1_Rx c1Rx;

  modport to_fiu (input reset, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
                  output c0Tx, c1Tx, c2Tx);
  modport to_afu (output reset, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
                  input c0Tx, c1Tx, c2Tx);
endinterface

// File: rtl/cci_mpf_shim_tx_fifo.sv
// Per-channel Tx FIFO: storage, occupancy, registered almost-full, overflow and high-water.
module cci_mpf_shim_tx_fifo #(
  parameter int N_ENTRIES      = 16,
  parameter int N_DATA_BITS    = 8,
  parameter int ALM_FULL_SLACK = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enq_en,
  input  logic [N_DATA_BITS-1:0]             enq_data,
  input  logic                               out_blocked,
  output logic                               deq,
  output logic [N_DATA_BITS-1:0]             first,
  output logic                               alm_full,
  output logic [$clog2(N_ENTRIES+1)-1:0]     max_occ,
  output logic                               overflow
);
  localparam int OCC_W = $clog2(N_ENTRIES + 1);
  localparam int PTR_W = $clog2(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [OCC_W-1:0]       occ, occ_next;
  logic                   full, enq_ok;

  assign full   = (occ == OCC_W'(N_ENTRIES));
  assign deq    = (occ != '0) && !out_blocked;
  // A write into a full FIFO survives only when the head leaves the same cycle.
  assign enq_ok = enq_en && (!full || deq);
  assign first  = mem[rd_ptr];

  // Next occupancy; enq+deq together leave the count alone.
  always_comb begin
    occ_next = occ;
    if (enq_ok && !deq)      occ_next = occ + 1'b1;
    else if (!enq_ok && deq) occ_next = occ - 1'b1;
  end

  // Storage write; reading and overwriting the same slot at full returns the old head.
  always_ff @(posedge clk) begin
    if (enq_ok && !reset) mem[wr_ptr] <= enq_data;
  end

  // Pointers wrap naturally (power-of-2 depth); status flags are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      alm_full <= 1'b1;
      max_occ  <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
      if (deq)    rd_ptr <= rd_ptr + 1'b1;
      occ      <= occ_next;
      alm_full <= (OCC_W'(N_ENTRIES) - occ_next) <= OCC_W'(ALM_FULL_SLACK);
      if (occ_next > max_occ) max_occ <= occ_next;
      if (enq_en && !enq_ok)  overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/cci_mpf_shim_buffered_if.sv
// Buffered/registered bridge between an AFU-side and FIU-side CCI-MPF interface.
module cci_mpf_shim_buffered_if
  import cci_mpf_shim_buffered_pkg::*;
#(
  parameter int C0_DEPTH       = 16,
  parameter int C1_DEPTH       = 16,
  parameter int ALM_FULL_SLACK = 8,
  parameter bit REGISTER_RX    = 1'b1,
  parameter bit REGISTER_C2    = 1'b1
) (
  input  logic                          clk,
  cci_mpf_if.to_fiu                     fiu,
  cci_mpf_if.to_afu                     afu,
  output logic [occ_w(C0_DEPTH)-1:0]    c0_max_occ,
  output logic [occ_w(C1_DEPTH)-1:0]    c1_max_occ,
  output logic [1:0]                    err_overflow
);
  logic              c0_deq, c1_deq, c0_alm, c1_alm;
  t_if_cci_mpf_c0_Tx c0_first;
  t_if_cci_mpf_c1_Tx c1_first;

  cci_mpf_shim_tx_fifo #(
    .N_ENTRIES(C0_DEPTH), .N_DATA_BITS($bits(t_if_cci_mpf_c0_Tx)), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c0 (
    .clk(clk), .reset(fiu.reset), .enq_en(afu.c0Tx.valid), .enq_data(afu.c0Tx),
    .out_blocked(fiu.c0TxAlmFull), .deq(c0_deq), .first(c0_first), .alm_full(c0_alm),
    .max_occ(c0_max_occ), .overflow(err_overflow[0])
  );

  cci_mpf_shim_tx_fifo #(
    .N_ENTRIES(C1_DEPTH), .N_DATA_BITS($bits(t_if_cci_mpf_c1_Tx)), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c1 (
    .clk(clk), .reset(fiu.reset), .enq_en(afu.c1Tx.valid), .enq_data(afu.c1Tx),
    .out_blocked(fiu.c1TxAlmFull), .deq(c1_deq), .first(c1_first), .alm_full(c1_alm),
    .max_occ(c1_max_occ), .overflow(err_overflow[1])
  );

  assign afu.c0TxAlmFull = c0_alm;
  assign afu.c1TxAlmFull = c1_alm;

  // Reset is re-timed one cycle toward the AFU.
  always_ff @(posedge clk) afu.reset <= fiu.reset;

  // Tx output registers: present the dequeued head one cycle after the decision.
  always_ff @(posedge clk) begin
    if (fiu.reset) begin
      fiu.c0Tx <= '0;
      fiu.c1Tx <= '0;
    end else begin
      fiu.c0Tx <= c0_deq ? c0_first : '0;
      fiu.c1Tx <= c1_deq ? c1_first : '0;
    end
  end

  generate
    if (REGISTER_C2) begin : g_c2_reg
      // MMIO responses are never back-pressured; just one pipeline stage.
      always_ff @(posedge clk) begin
        if (fiu.reset) fiu.c2Tx <= '0;
        else           fiu.c2Tx <= afu.c2Tx;
      end
    end else begin : g_c2_pass
      // Pass-through with the valid masked during reset.
      always_comb begin
        fiu.c2Tx = afu.c2Tx;
        if (fiu.reset) fiu.c2Tx.mmioRdValid = 1'b0;
      end
    end

    if (REGISTER_RX) begin : g_rx_reg
      // One-cycle Rx delay, every valid bit carried unchanged.
      always_ff @(posedge clk) begin
        if (fiu.reset) begin
          afu.c0Rx <= '0;
          afu.c1Rx <= '0;
        end else begin
          afu.c0Rx <= fiu.c0Rx;
          afu.c1Rx <= fiu.c1Rx;
        end
      end
    end else begin : g_rx_pass
      // Combinational Rx with valids masked during reset.
      always_comb begin
        afu.c0Rx = fiu.c0Rx;
        afu.c1Rx = fiu.c1Rx;
        if (fiu.reset) begin
          afu.c0Rx.rspValid    = 1'b0;
          afu.c0Rx.mmioRdValid = 1'b0;
          afu.c0Rx.mmioWrValid = 1'b0;
          afu.c1Rx.rspValid    = 1'b0;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_cci_mpf_shim_buffered_if.sv
// Scoreboard bench: queue-based reference model at posedge, monitor compares at negedge.
module tb_cci_mpf_shim_buffered_if;
  import cci_mpf_shim_buffered_pkg::*;

  localparam int D = 16;
  localparam int S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  cci_mpf_if fiu_if();
  cci_mpf_if afu_if();
  logic [4:0] c0_max_occ, c1_max_occ;
  logic [1:0] err_overflow;

  cci_mpf_shim_buffered_if #(
    .C0_DEPTH(D), .C1_DEPTH(D), .ALM_FULL_SLACK(S), .REGISTER_RX(1'b1), .REGISTER_C2(1'b1)
  ) dut (
    .clk(clk), .fiu(fiu_if), .afu(afu_if),
    .c0_max_occ(c0_max_occ), .c1_max_occ(c1_max_occ), .err_overflow(err_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: FIFO contents as queues, expected outputs as scoreboards.
  logic [80:0]       mq [2][$];
  logic [80:0]       ex [2][$];
  bit                m_alm [2];
  int                m_max [2];
  bit [1:0]          m_err;
  bit                m_afu_rst;
  t_if_cci_mpf_c0_Rx ex_c0rx;
  t_if_cci_mpf_c1_Rx ex_c1rx;
  t_if_cci_mpf_c2_Tx ex_c2;
  bit                started = 0;

  task automatic model_step();
    bit          en [2];
    bit          blk [2];
    logic [80:0] pl [2];
    en[0]  = afu_if.c0Tx.valid;  pl[0] = 81'(afu_if.c0Tx);  blk[0] = fiu_if.c0TxAlmFull;
    en[1]  = afu_if.c1Tx.valid;  pl[1] = 81'(afu_if.c1Tx);  blk[1] = fiu_if.c1TxAlmFull;
    m_afu_rst = fiu_if.reset;
    if (fiu_if.reset) begin
      for (int c = 0; c < 2; c++) begin
        mq[c].delete(); ex[c].delete(); m_alm[c] = 1; m_max[c] = 0;
      end
      m_err = 0; ex_c0rx = '0; ex_c1rx = '0; ex_c2 = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (mq[c].size() > 0 && !blk[c]) ex[c].push_back(mq[c].pop_front());
        if (en[c]) begin
          if (mq[c].size() < D) mq[c].push_back(pl[c]);
          else m_err[c] = 1;
        end
        m_alm[c] = (D - mq[c].size()) <= S;
        if (mq[c].size() > m_max[c]) m_max[c] = mq[c].size();
      end
      ex_c0rx = fiu_if.c0Rx;
      ex_c1rx = fiu_if.c1Rx;
      ex_c2   = afu_if.c2Tx;
    end
    started = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: every cycle, each Tx channel either owes exactly the scoreboard head or nothing.
  initial forever begin
    @(negedge clk);
    if (started) begin
      if (ex[0].size() > 0) chk("c0tx_payload", 128'(fiu_if.c0Tx), 128'(ex[0].pop_front()));
      else                  chk("c0tx_idle",    128'(fiu_if.c0Tx.valid), 128'(0));
      if (ex[1].size() > 0) chk("c1tx_payload", 128'(fiu_if.c1Tx), 128'(ex[1].pop_front()));
      else                  chk("c1tx_idle",    128'(fiu_if.c1Tx.valid), 128'(0));
      chk("c0_almfull", 128'(afu_if.c0TxAlmFull), 128'(m_alm[0]));
      chk("c1_almfull", 128'(afu_if.c1TxAlmFull), 128'(m_alm[1]));
      chk("c0_max_occ", 128'(c0_max_occ), 128'(m_max[0]));
      chk("c1_max_occ", 128'(c1_max_occ), 128'(m_max[1]));
      chk("err_overflow", 128'(err_overflow), 128'(m_err));
      chk("afu_reset", 128'(afu_if.reset), 128'(m_afu_rst));
      chk("c0rx", 128'(afu_if.c0Rx), 128'(ex_c0rx));
      chk("c1rx", 128'(afu_if.c1Rx), 128'(ex_c1rx));
      chk("c2tx", 128'(fiu_if.c2Tx), 128'(ex_c2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tx();
    afu_if.c0Tx = '0;
    afu_if.c1Tx = '0;
  endtask

  task automatic put_c0();
    afu_if.c0Tx = {1'b1, 16'($urandom)};
  endtask

  task automatic put_c1();
    afu_if.c1Tx = {1'b1, 16'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  initial begin
    fiu_if.reset = 1'b1;
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    fiu_if.c0Rx = '0;
    fiu_if.c1Rx = '0;
    afu_if.c2Tx = '0;
    idle_tx();

    // Reset release after 5 clocks.
    repeat (5) step();
    fiu_if.reset = 1'b0;
    step();

    // Single c0 request: payload 2 clocks later, high-water 1.
    put_c0(); step(); idle_tx();
    repeat (3) step();
    chk("single_max_occ", 128'(c0_max_occ), 128'(1));

    // Back-pressure fill on c1.
    fiu_if.c1TxAlmFull = 1'b1;
    for (int i = 0; i < 8; i++) begin put_c1(); step(); end
    chk("c1_alm_after_8", 128'(afu_if.c1TxAlmFull), 128'(1));
    for (int i = 0; i < 8; i++) begin put_c1(); step(); end
    idle_tx(); step();
    chk("c1_fill_occ", 128'(c1_max_occ), 128'(16));
    chk("c1_fill_noerr", 128'(err_overflow), 128'(0));
    fiu_if.c1TxAlmFull = 1'b0;
    repeat (20) step();

    // Overflow on c0, then a full-FIFO write accepted alongside a dequeue.
    fiu_if.c0TxAlmFull = 1'b1;
    for (int i = 0; i < 17; i++) begin put_c0(); step(); end
    idle_tx(); step();
    chk("c0_overflow", 128'(err_overflow), 128'(2'b01));
    fiu_if.c0TxAlmFull = 1'b0; put_c0(); step();
    idle_tx(); repeat (20) step();
    chk("c0_overflow_sticky", 128'(err_overflow), 128'(2'b01));
    chk("c0_max_saturated", 128'(c0_max_occ), 128'(16));

    // Steady back-to-back traffic after a fresh reset: occupancy stays at 1.
    fiu_if.reset = 1'b1; repeat (2) step(); fiu_if.reset = 1'b0; step();
    for (int i = 0; i < 100; i++) begin put_c0(); step(); end
    chk("steady_max_occ", 128'(c0_max_occ), 128'(1));
    // Reset in the middle of the stream.
    fiu_if.reset = 1'b1; step();
    chk("midreset_c0_valid", 128'(fiu_if.c0Tx.valid), 128'(0));
    idle_tx(); step(); fiu_if.reset = 1'b0; step();

    // Randomised traffic on all channels with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (afu_if.c0TxAlmFull == 1'b0 || $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 2) != 0) put_c0(); else afu_if.c0Tx = '0;
      end else afu_if.c0Tx = '0;
      if (afu_if.c1TxAlmFull == 1'b0 || $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 2) != 0) put_c1(); else afu_if.c1Tx = '0;
      end else afu_if.c1Tx = '0;
      fiu_if.c0TxAlmFull = ($urandom_range(0, 3) == 0);
      fiu_if.c1TxAlmFull = ($urandom_range(0, 2) == 0);
      fiu_if.c0Rx = {3'($urandom), 16'($urandom), 32'($urandom), 32'($urandom)};
      fiu_if.c1Rx = {1'($urandom), 16'($urandom)};
      afu_if.c2Tx = {1'($urandom), 9'($urandom), 32'($urandom), 32'($urandom)};
      fiu_if.reset = (i == 300 || i == 301);
      step();
    end
    idle_tx();
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    afu_if.c2Tx = '0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
